// File: rtl/Falco_pkg.sv
// ============================================================================
// Falco_pkg : shared core types for the integer register-read stage
// Rev 1.0
// ============================================================================
`default_nettype none

package Falco_pkg;

    localparam int XLEN    = 32;
    localparam int PRF_NUM = 64;
    localparam int PRF_W   = $clog2(PRF_NUM);
    localparam int ROB_W   = 5;
    localparam int UOP_W   = 8;
    localparam int NUM_WB  = 4;

    typedef logic [PRF_W-1:0] prf_specifier_t;
    typedef logic [XLEN-1:0]  xlen_data_t;

    typedef struct packed {
        logic           valid;
        prf_specifier_t wb_addr;
        xlen_data_t     wb_data;
    } exe_fu_wb_t;

    // Pass-through uop fields that ride alongside the resolved operands
    typedef struct packed {
        prf_specifier_t   rd;
        xlen_data_t       pc;
        logic [ROB_W-1:0] rob;
        logic [UOP_W-1:0] op;
    } rr_uop_t;

endpackage

`default_nettype wire

// File: rtl/rr_bypass_mux.sv
// ============================================================================
// rr_bypass_mux : resolves one source operand from PRF data and four wb buses
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_bypass_mux
    import Falco_pkg::*;
(
    input  prf_specifier_t src,
    input  xlen_data_t     prf_data,
    input  exe_fu_wb_t     alu_csr_bc_wb,
    input  exe_fu_wb_t     alu1_wb,
    input  exe_fu_wb_t     muldiv_wb,
    input  exe_fu_wb_t     mem_wb,
    output xlen_data_t     value
);

    exe_fu_wb_t w_bus [NUM_WB];

    assign w_bus[0] = alu_csr_bc_wb;
    assign w_bus[1] = alu1_wb;
    assign w_bus[2] = muldiv_wb;
    assign w_bus[3] = mem_wb;

    // Walk from lowest to highest priority so the earliest matching bus wins
    always_comb begin
        value = prf_data;
        for (int i = NUM_WB - 1; i >= 0; i--) begin
            if (w_bus[i].valid && (w_bus[i].wb_addr == src)) begin
                value = w_bus[i].wb_data;
            end
        end
        if (src == '0) begin
            value = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/int_register_read_stage.sv
// ============================================================================
// int_register_read_stage : INT lane register read with wb bypass and a
// single-entry pipeline register toward execute.  Rev 1.0
// ============================================================================
`default_nettype none

module int_register_read_stage
    import Falco_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  prf_specifier_t   in_rs1,
    input  prf_specifier_t   in_rs2,
    input  prf_specifier_t   in_rd,
    input  logic             in_use_imm,
    input  xlen_data_t       in_imm,
    input  xlen_data_t       in_pc,
    input  logic [ROB_W-1:0] in_rob,
    input  logic [UOP_W-1:0] in_op,
    output prf_specifier_t   prf_rs1_addr,
    output prf_specifier_t   prf_rs2_addr,
    input  xlen_data_t       prf_rs1_data,
    input  xlen_data_t       prf_rs2_data,
    input  exe_fu_wb_t       alu_csr_bc_wb,
    input  exe_fu_wb_t       alu1_wb,
    input  exe_fu_wb_t       muldiv_wb,
    input  exe_fu_wb_t       mem_wb,
    output logic             out_valid,
    input  logic             out_ready,
    output xlen_data_t       out_op1,
    output xlen_data_t       out_op2,
    output xlen_data_t       out_rs2_val,
    output prf_specifier_t   out_rd,
    output xlen_data_t       out_pc,
    output logic [ROB_W-1:0] out_rob,
    output logic [UOP_W-1:0] out_op,
    output logic [31:0]      stall_cnt
);

    xlen_data_t w_rs1_val;
    xlen_data_t w_rs2_val;
    logic       w_capture;
    rr_uop_t    r_uop;

    assign prf_rs1_addr = in_rs1;
    assign prf_rs2_addr = in_rs2;

    rr_bypass_mux u_rs1_bypass (
        .src           (in_rs1),
        .prf_data      (prf_rs1_data),
        .alu_csr_bc_wb (alu_csr_bc_wb),
        .alu1_wb       (alu1_wb),
        .muldiv_wb     (muldiv_wb),
        .mem_wb        (mem_wb),
        .value         (w_rs1_val)
    );

    rr_bypass_mux u_rs2_bypass (
        .src           (in_rs2),
        .prf_data      (prf_rs2_data),
        .alu_csr_bc_wb (alu_csr_bc_wb),
        .alu1_wb       (alu1_wb),
        .muldiv_wb     (muldiv_wb),
        .mem_wb        (mem_wb),
        .value         (w_rs2_val)
    );

    assign in_ready  = !out_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_rs2_val <= '0;
            r_uop       <= '0;
            stall_cnt   <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end

            // Flush beats both a new capture and a drain
            if (flush) begin
                out_valid <= 1'b0;
            end else if (w_capture) begin
                out_valid   <= 1'b1;
                out_op1     <= w_rs1_val;
                out_op2     <= in_use_imm ? in_imm : w_rs2_val;
                out_rs2_val <= w_rs2_val;
                r_uop       <= '{rd: in_rd, pc: in_pc, rob: in_rob, op: in_op};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_rd  = r_uop.rd;
    assign out_pc  = r_uop.pc;
    assign out_rob = r_uop.rob;
    assign out_op  = r_uop.op;

endmodule

`default_nettype wire

// File: tb/tb_int_register_read_stage.sv
// ============================================================================
// tb_int_register_read_stage : scoreboard bench for int_register_read_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_int_register_read_stage;
    import Falco_pkg::*;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rs2v;
        logic [31:0] pc;
        logic [5:0]  rd;
        logic [4:0]  rob;
        logic [7:0]  op;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    prf_specifier_t   in_rs1, in_rs2, in_rd;
    logic             in_use_imm;
    xlen_data_t       in_imm, in_pc;
    logic [ROB_W-1:0] in_rob;
    logic [UOP_W-1:0] in_op;
    prf_specifier_t   prf_rs1_addr, prf_rs2_addr;
    xlen_data_t       prf_rs1_data, prf_rs2_data;
    exe_fu_wb_t       alu_csr_bc_wb, alu1_wb, muldiv_wb, mem_wb;
    logic             out_valid;
    logic             out_ready;
    xlen_data_t       out_op1, out_op2, out_rs2_val, out_pc;
    prf_specifier_t   out_rd;
    logic [ROB_W-1:0] out_rob;
    logic [UOP_W-1:0] out_op;
    logic [31:0]      stall_cnt;

    logic [31:0] prf_mem [PRF_NUM];
    exp_t        sb_q [$];
    logic        m_valid;
    logic        m_next;
    logic [31:0] m_stall;
    logic        mon_en;
    int          total;
    int          bad;

    assign prf_rs1_data = prf_mem[prf_rs1_addr];
    assign prf_rs2_data = prf_mem[prf_rs2_addr];

    int_register_read_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_pc(in_pc),
        .in_rob(in_rob), .in_op(in_op),
        .prf_rs1_addr(prf_rs1_addr), .prf_rs2_addr(prf_rs2_addr),
        .prf_rs1_data(prf_rs1_data), .prf_rs2_data(prf_rs2_data),
        .alu_csr_bc_wb(alu_csr_bc_wb), .alu1_wb(alu1_wb),
        .muldiv_wb(muldiv_wb), .mem_wb(mem_wb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_pc(out_pc), .out_rob(out_rob), .out_op(out_op),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: x0 reads zero, else first matching bus in priority order, else the file
    function automatic logic [31:0] resolve(input logic [5:0] a, input exe_fu_wb_t w [4]);
        if (a == 6'd0) return 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (w[i].valid && w[i].wb_addr == a) return w[i].wb_data;
        end
        return prf_mem[a];
    endfunction

    task automatic drive(input logic v, input logic [5:0] r1, input logic [5:0] r2,
                         input logic [5:0] rd, input logic ui, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] rob, input logic [7:0] op,
                         input logic ordy, input logic fl,
                         input exe_fu_wb_t w0, input exe_fu_wb_t w1,
                         input exe_fu_wb_t w2, input exe_fu_wb_t w3);
        exe_fu_wb_t w [4];
        exp_t       e;
        logic       cap;
        @(posedge clk);
        #1;
        if (m_valid && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        m_valid = m_next;
        in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_use_imm = ui;
        in_imm = imm; in_pc = pc; in_rob = rob; in_op = op;
        out_ready = ordy; flush = fl;
        alu_csr_bc_wb = w0; alu1_wb = w1; muldiv_wb = w2; mem_wb = w3;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        cap = v && (!m_valid || ordy) && !fl;
        if (cap) begin
            e.op1  = resolve(r1, w);
            e.rs2v = resolve(r2, w);
            e.op2  = ui ? imm : e.rs2v;
            e.pc = pc; e.rd = rd; e.rob = rob; e.op = op;
            sb_q.push_back(e);
        end
        m_next = fl ? 1'b0 : cap ? 1'b1 : ordy ? 1'b0 : m_valid;
    endtask

    function automatic exe_fu_wb_t rand_wb();
        exe_fu_wb_t w;
        w.valid   = 1'($urandom_range(0, 1));
        w.wb_addr = 6'($urandom_range(0, 7));
        w.wb_data = $urandom;
        return w;
    endfunction

    function automatic logic [5:0] rand_reg();
        if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
        return 6'($urandom_range(0, 7));
    endfunction

    // Monitor: compares the presented uop against the scoreboard head every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
            chk("stall_cnt", stall_cnt, m_stall);
            if (m_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got out_valid=1 expected no pending uop at %0t", $time);
                end else begin
                    chk("op1", out_op1, sb_q[0].op1);
                    chk("op2", out_op2, sb_q[0].op2);
                    chk("rs2_val", out_rs2_val, sb_q[0].rs2v);
                    chk("pc", out_pc, sb_q[0].pc);
                    chk("rd", {26'd0, out_rd}, {26'd0, sb_q[0].rd});
                    chk("rob", {27'd0, out_rob}, {27'd0, sb_q[0].rob});
                    chk("op", {24'd0, out_op}, {24'd0, sb_q[0].op});
                    if (out_ready || flush) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        exe_fu_wb_t n;
        exe_fu_wb_t wa;
        exe_fu_wb_t wb;
        n = '0;
        total = 0; bad = 0;
        m_valid = 1'b0; m_next = 1'b0; m_stall = 32'd0; mon_en = 1'b0;
        for (int i = 0; i < PRF_NUM; i++) prf_mem[i] = $urandom;
        prf_mem[0] = 32'd0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_use_imm = 1'b0;
        in_imm = '0; in_pc = '0; in_rob = '0; in_op = '0;
        alu_csr_bc_wb = '0; alu1_wb = '0; muldiv_wb = '0; mem_wb = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_op1", out_op1, 32'd0);
        chk("rst_op2", out_op2, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        mon_en = 1'b1;

        // Plain read
        prf_mem[5] = 32'h11; prf_mem[7] = 32'h22;
        drive(1, 5, 7, 3, 0, 0, 32'h100, 1, 8'h01, 1, 0, n, n, n, n);
        // Bypass priority: alu1 beats mem, then mem alone
        prf_mem[9] = 32'h0;
        wa = '{1'b1, 6'd9, 32'hAAAA};
        wb = '{1'b1, 6'd9, 32'hBBBB};
        drive(1, 9, 7, 4, 0, 0, 32'h104, 2, 8'h02, 1, 0, n, wa, n, wb);
        drive(1, 9, 7, 4, 0, 0, 32'h108, 3, 8'h03, 1, 0, n, n, n, wb);
        // x0 ignores a bus aimed at r0; immediate replaces operand 2
        wa = '{1'b1, 6'd0, 32'hFFFF};
        drive(1, 0, 5, 6, 1, 32'h7FF, 32'h10C, 4, 8'h04, 1, 0, wa, n, n, n);
        // Backpressure: hold three cycles with the next uop waiting
        drive(1, 5, 7, 8, 0, 0, 32'h200, 5, 8'h05, 1, 0, n, n, n, n);
        repeat (3) drive(1, 7, 5, 9, 0, 0, 32'h204, 6, 8'h06, 0, 0, n, n, n, n);
        drive(1, 7, 5, 9, 0, 0, 32'h204, 6, 8'h06, 1, 0, n, n, n, n);
        // Flush with a simultaneous issue: nothing survives
        drive(1, 5, 5, 10, 0, 0, 32'h300, 7, 8'h07, 0, 0, n, n, n, n);
        drive(1, 7, 7, 11, 0, 0, 32'h304, 8, 8'h08, 1, 1, n, n, n, n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, n, n, n, n);

        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_reg(), rand_reg(), rand_reg(),
                  1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom),
                  8'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) == 0),
                  rand_wb(), rand_wb(), rand_wb(), rand_wb());
        end

        // Async reset while a stalled uop is held
        drive(1, 5, 7, 12, 0, 0, 32'h400, 9, 8'h09, 1, 0, n, n, n, n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, n, n, n, n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, n, n, n, n);
        @(negedge clk);
        #1 mon_en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_stall", stall_cnt, 32'd0);
        chk("arst_op1", out_op1, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
